// File: rtl/register_dump_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_dump_reader_pkg
// Description : Shared state encoding, default sizes and small helpers for
//               the register dump reader and its output stage.
// Revision    : 1.0 - initial release
// ============================================================================
package register_dump_reader_pkg;

    // Default geometry of the scanned register file.
    localparam int NUM_REGS_DEF = 8;
    localparam int DATA_W_DEF   = 8;
    localparam int ADDR_W_DEF   = 3;
    localparam int RD_LAT_DEF   = 1;

    // Register file read-address width; bits above the register index are tied 0.
    localparam int RF_ADDR_W    = 4;

    // Sequencer states; encodings are fixed so debug captures stay comparable.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_PRESENT = 2'd3
    } state_t;

    // Width of the read-latency down-counter; never narrower than one bit
    // so a latency of 1 still yields a legal vector.
    function automatic int lat_cnt_width(input int rd_lat);
        return (rd_lat > 1) ? $clog2(rd_lat) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_dump_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : register_dump_reader_if
// Description : Bundles the register-file read port and the valid/ready
//               (address, data, last) output stream of the dump reader.
//               master = the reader, slave = register file + consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface register_dump_reader_if
    import register_dump_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    // Register file read port.
    logic [RF_ADDR_W-1:0] rf_read_address;
    logic [DATA_W-1:0]    rf_read_data;

    // Output byte stream.
    logic                 out_valid;
    logic                 out_ready;
    logic [ADDR_W-1:0]    out_addr;
    logic [DATA_W-1:0]    out_data;
    logic                 out_last;

    modport master (
        output rf_read_address,
        input  rf_read_data,
        output out_valid,
        input  out_ready,
        output out_addr,
        output out_data,
        output out_last
    );

    modport slave (
        input  rf_read_address,
        output rf_read_data,
        input  out_valid,
        output out_ready,
        input  out_addr,
        input  out_data,
        input  out_last
    );

endinterface
`default_nettype wire

// File: rtl/register_dump_reader_out_stage.sv
`default_nettype none
// ============================================================================
// Module      : register_dump_reader_out_stage
// Description : Single-entry output holding register with valid/ready.
//               Loads a (addr, data, last) entry, holds it unchanged while
//               the consumer stalls, and drops valid on acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module register_dump_reader_out_stage
    import register_dump_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  wire logic              clock_reg,
    input  wire logic              reset,
    input  wire logic              load,
    input  wire logic [ADDR_W-1:0] load_addr,
    input  wire logic [DATA_W-1:0] load_data,
    input  wire logic              load_last,
    input  wire logic              ready,
    output logic                   valid,
    output logic [ADDR_W-1:0]      addr,
    output logic [DATA_W-1:0]      data,
    output logic                   last
);

    // Capture on load, hold while stalled, clear valid once the entry is taken.
    // The payload is left in place after acceptance; only valid qualifies it.
    always_ff @(posedge clock_reg or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= load_addr;
            data  <= load_data;
            last  <= load_last;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/register_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : register_dump_reader
// Description : Walks registers 0..NUM_REGS-1 through one read port and
//               streams each (address, data) pair out on a valid/ready
//               interface. One dump per start pulse, or back-to-back dumps
//               while continuous is held high.
// Revision    : 1.0 - initial release
// ============================================================================
module register_dump_reader
    import register_dump_reader_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int RD_LAT   = RD_LAT_DEF
) (
    input  wire logic              clock_reg,
    input  wire logic              reset,
    input  wire logic              start,
    input  wire logic              continuous,
    output logic                   busy,
    output logic                   done,
    register_dump_reader_if.master bus
);

    // The counter is loaded with RD_LAT-1 in ISSUE and the capture happens
    // when it reads zero in WAIT, so WAIT lasts exactly RD_LAT cycles and the
    // read data is sampled on the RD_LAT-th edge after the address moved.
    localparam int                LAT_W      = lat_cnt_width(RD_LAT);
    localparam logic [LAT_W-1:0]  LAT_INIT   = LAT_W'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(NUM_REGS - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_index;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic                r_busy;
    logic                r_done;

    logic                w_load;
    logic                w_load_last;
    logic                w_accept;

    // Capture strobe for the output stage: last WAIT cycle.
    assign w_load      = (r_state == ST_WAIT) && (r_lat_cnt == '0);
    assign w_load_last = (r_index == LAST_INDEX);

    // An entry leaves the reader only while PRESENT holds a valid entry.
    assign w_accept    = (r_state == ST_PRESENT) && bus.out_valid && bus.out_ready;

    // The read address is a register updated only in ISSUE, so it stays
    // constant through WAIT and the capture edge. Upper bits are tied 0.
    assign bus.rf_read_address = RF_ADDR_W'(r_rd_addr);

    assign busy = r_busy;
    assign done = r_done;

    // Sequencer: start gating, read issue, latency wait, handshake and wrap.
    // busy tracks "state != IDLE" as a register; done is a one-cycle pulse.
    always_ff @(posedge clock_reg or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_index   <= '0;
            r_rd_addr <= '0;
            r_lat_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // start is only looked at here, so pulses while busy are dropped.
                    if (start) begin
                        r_state <= ST_ISSUE;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    r_rd_addr <= r_index;
                    r_lat_cnt <= LAT_INIT;
                    r_state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_lat_cnt == '0) begin
                        r_state <= ST_PRESENT;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    end
                end
                ST_PRESENT: begin
                    if (w_accept) begin
                        if (!bus.out_last) begin
                            r_index <= r_index + ADDR_W'(1);
                            r_state <= ST_ISSUE;
                        end else begin
                            // The index wraps only here, after the final entry.
                            r_done  <= 1'b1;
                            r_index <= '0;
                            if (continuous) begin
                                r_state <= ST_ISSUE;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register: loaded from the read port on the capture
    // strobe, held stable under backpressure.
    register_dump_reader_out_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_out_stage (
        .clock_reg (clock_reg),
        .reset     (reset),
        .load      (w_load),
        .load_addr (r_index),
        .load_data (bus.rf_read_data),
        .load_last (w_load_last),
        .ready     (bus.out_ready),
        .valid     (bus.out_valid),
        .addr      (bus.out_addr),
        .data      (bus.out_data),
        .last      (bus.out_last)
    );

endmodule
`default_nettype wire
